sd_conv_sequencer: RTL and testbench
====================================

Name: sd_conv_sequencer

Overview:
Sequences the sigma-delta ADC decimation path for a multi-channel DMM front end. The block selects the analog input mux, holds off for mux settling, and clears the decimator. It then discards the first decimated words while the filter settles and averages a set number of valid words. Each per-channel result is returned over a valid/ready handshake, either for a single scan or in continuous round-robin.

Parameters:
NCH, 4, number of analog input channels
CH_W, 2, width of channel index (clog2 NCH)
DW, 33, decimated word width
SETTLE_CYC, 16, clk cycles held after mux change before clearing decimator (min 1)
DISCARD, 2, decimated words dropped after each clear (0 allowed)
AVG_LOG2, 2, log2 of words averaged per result (0..6)
OVR_THRESH, 33'h1_FFFF_FF00, sample value at or above which overrange is flagged

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse; begins a scan, ignored while busy
continuous  in  1  sampled with start; 1 = repeat scan until abort
ch_mask  in  NCH  channel enable mask, sampled with start
abort  in  1  terminate scan, return to IDLE next cycle
dec_valid  in  1  1-cycle strobe, dec_data holds a new decimated word
dec_data  in  DW  decimated word, unsigned
mux_sel  out  CH_W  analog mux select
dec_clear  out  1  1-cycle pulse, clears decimator accumulator/counter
busy  out  1  high in any state other than IDLE
res_data  out  DW  averaged result
res_ch  out  CH_W  channel of res_data
res_ovr  out  1  any averaged word >= OVR_THRESH
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
err_mask  out  1  1-cycle pulse: start seen with ch_mask == 0

Behaviour:
- Reset (reset low, async): state IDLE; mux_sel=0, dec_clear=0, busy=0, res_data=0, res_ch=0, res_ovr=0, res_valid=0, err_mask=0; internal masks, counters and accumulator cleared.
- States: IDLE, SWITCH, CLEAR, FLUSH, ACCUM, OUTPUT.
- IDLE: start & mask!=0 -> latch mask/continuous; cur = lowest set bit; mux_sel<=cur; -> SWITCH.
- IDLE: start & mask==0 -> err_mask pulse next cycle; stay in IDLE.
- SWITCH: count SETTLE_CYC cycles, then -> CLEAR. dec_valid is ignored in this state.
- CLEAR: dec_clear=1 for exactly one cycle; zero the word counter, accumulator and ovr flag; -> FLUSH if DISCARD>0, else -> ACCUM.
- FLUSH: count dec_valid strobes; the DISCARD-th strobe -> ACCUM. Data is dropped.
- ACCUM: on each dec_valid, acc += dec_data. acc width is DW+AVG_LOG2, so it cannot overflow. ovr |= (dec_data >= OVR_THRESH).
- ACCUM exit: on the 2^AVG_LOG2-th strobe, res_data <= (acc + dec_data) >> AVG_LOG2 (truncate), res_ch <= cur, res_ovr <= final ovr, res_valid <= 1; -> OUTPUT.
- OUTPUT: hold res_* stable while res_valid & !res_ready. dec_valid strobes here are dropped.
- OUTPUT, on res_valid & res_ready: res_valid <= 0. Select the next set bit after cur in the latched mask, wrapping modulo NCH.
  - If the scan wrapped past the top channel and continuous=0 -> IDLE.
  - Otherwise mux_sel <= next and -> SWITCH.
- Single-bit mask with continuous=1: the same channel repeats and still passes through SWITCH.
- Latency, single channel, no stalls: first res_valid = 1 (IDLE) + SETTLE_CYC + 1 (CLEAR) + cycles until the (DISCARD + 2^AVG_LOG2)-th dec_valid, plus 1 cycle registered.
- abort (any non-IDLE state): next cycle IDLE, res_valid=0, busy=0. An unaccepted result is discarded; this is the only case where valid drops without ready. mux_sel keeps its last value. abort beats every same-cycle event, including res_ready and dec_valid.
- start while busy: ignored. Changes to ch_mask or continuous after start: no effect until the next start.
- dec_valid in the same cycle as dec_clear: ignored.

Test Plan:
- Single channel: mask=4'b0100, continuous=0, dec_data=100,104,108,112 after 2 discards -> mux_sel=2; dec_clear fires after 16 cycles; res_data=106, res_ch=2, res_ovr=0; busy drops after handshake.
- Scan order: mask=4'b1011, constant dec_data=K -> results in order ch0, ch1, ch3, each =K; returns to IDLE after ch3.
- Backpressure: res_ready low for 20 cycles with dec_valid strobes arriving -> res_data/res_ch stay stable; strobes dropped; next channel result is correct.
- Overrange and truncation: one word =33'h1_FFFF_FFFF among 3, plus words 0,1,2 -> res_ovr=1; res_data = floor(sum/4).
- Continuous + abort: mask=4'b0001, continuous=1; three results accepted; abort during FLUSH -> IDLE next cycle, busy=0, no further res_valid.
- Boundaries: start with mask=0 -> err_mask 1-cycle pulse, busy stays 0. Reset asserted mid-ACCUM -> all outputs at reset values immediately. DISCARD=0 build -> CLEAR goes straight to ACCUM.

Source files
------------

// File: rtl/sd_conv_sequencer.sv
// Sigma-delta decimation sequencer: selects the input mux, waits for settling, clears the
// decimator, drops filter-settling words, averages a block of words and hands out one result per channel.
module sd_conv_sequencer #(
    parameter int              NCH        = 4,
    parameter int              CH_W       = 2,
    parameter int              DW         = 33,
    parameter int              SETTLE_CYC = 16,
    parameter int              DISCARD    = 2,
    parameter int              AVG_LOG2   = 2,
    parameter logic [DW-1:0]   OVR_THRESH = 33'h1_FFFF_FF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              abort,
    input  logic              dec_valid,
    input  logic [DW-1:0]     dec_data,
    output logic [CH_W-1:0]   mux_sel,
    output logic              dec_clear,
    output logic              busy,
    output logic [DW-1:0]     res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_ovr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              err_mask
);

    localparam int AVG_N  = 1 << AVG_LOG2;
    localparam int WC_MAX = (DISCARD > AVG_N) ? DISCARD : AVG_N;
    localparam int WC_W   = $clog2(WC_MAX + 1);
    localparam int ST_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int AW     = DW + AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_SWITCH, S_CLEAR, S_FLUSH, S_ACCUM, S_OUTPUT
    } state_t;

    state_t            r_state, w_next;
    logic [NCH-1:0]    r_mask;
    logic              r_cont;
    logic [CH_W-1:0]   r_mux;
    logic [ST_W-1:0]   r_settle_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [AW-1:0]     r_acc;
    logic              r_ovr;
    logic [DW-1:0]     r_res_data;
    logic [CH_W-1:0]   r_res_ch;
    logic              r_res_ovr;
    logic              r_res_valid;
    logic              r_err_mask;

    logic [WC_W-1:0]   w_wc_inc;
    logic [AW-1:0]     w_acc_sum;
    logic              w_ovr_any;
    logic              w_abort;
    logic              w_nxt_wrap;
    logic [CH_W-1:0]   w_nxt_ch;
    logic              w_scan_done;

    function automatic logic [DW-1:0] avg_trunc(input logic [AW-1:0] sum);
        logic [AW-1:0] sh;
        sh = sum >> AVG_LOG2;
        return sh[DW-1:0];
    endfunction

    function automatic logic [CH_W-1:0] first_set(input logic [NCH-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // MSB of the return value flags a wrap: no set bit above cur, so the lowest one is taken.
    function automatic logic [CH_W:0] next_set(input logic [NCH-1:0] m, input logic [CH_W-1:0] cur);
        logic            found;
        logic [CH_W-1:0] idx;
        found = 1'b0;
        idx   = first_set(m);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (CH_W'(i) > cur)) begin
                idx   = CH_W'(i);
                found = 1'b1;
            end
        end
        return {~found, idx};
    endfunction

    assign w_wc_inc    = r_word_cnt + 1'b1;
    assign w_acc_sum   = r_acc + AW'(dec_data);
    assign w_ovr_any   = r_ovr | (dec_data >= OVR_THRESH);
    assign w_abort     = abort && (r_state != S_IDLE);
    assign {w_nxt_wrap, w_nxt_ch} = next_set(r_mask, r_mux);
    assign w_scan_done = w_nxt_wrap && !r_cont;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && (ch_mask != '0)) w_next = S_SWITCH;
            S_SWITCH: if (r_settle_cnt == ST_W'(SETTLE_CYC - 1)) w_next = S_CLEAR;
            S_CLEAR:  w_next = (DISCARD > 0) ? S_FLUSH : S_ACCUM;
            S_FLUSH:  if (dec_valid && (w_wc_inc == WC_W'(DISCARD))) w_next = S_ACCUM;
            S_ACCUM:  if (dec_valid && (w_wc_inc == WC_W'(AVG_N))) w_next = S_OUTPUT;
            S_OUTPUT: if (r_res_valid && res_ready) w_next = w_scan_done ? S_IDLE : S_SWITCH;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask       <= '0;
            r_cont       <= 1'b0;
            r_mux        <= '0;
            r_settle_cnt <= '0;
            r_word_cnt   <= '0;
            r_acc        <= '0;
            r_ovr        <= 1'b0;
            r_res_data   <= '0;
            r_res_ch     <= '0;
            r_res_ovr    <= 1'b0;
            r_res_valid  <= 1'b0;
            r_err_mask   <= 1'b0;
        end else begin
            r_err_mask   <= 1'b0;
            r_settle_cnt <= (r_state == S_SWITCH) ? r_settle_cnt + 1'b1 : '0;
            // abort wins over handshake and strobes; mux_sel is left where it was
            if (w_abort) begin
                r_res_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && (ch_mask != '0)) begin
                            r_mask <= ch_mask;
                            r_cont <= continuous;
                            r_mux  <= first_set(ch_mask);
                        end else if (start) begin
                            r_err_mask <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        r_word_cnt <= '0;
                        r_acc      <= '0;
                        r_ovr      <= 1'b0;
                    end
                    S_FLUSH: begin
                        if (dec_valid)
                            r_word_cnt <= (w_wc_inc == WC_W'(DISCARD)) ? '0 : w_wc_inc;
                    end
                    S_ACCUM: begin
                        if (dec_valid) begin
                            r_acc      <= w_acc_sum;
                            r_ovr      <= w_ovr_any;
                            r_word_cnt <= w_wc_inc;
                            if (w_wc_inc == WC_W'(AVG_N)) begin
                                r_res_data  <= avg_trunc(w_acc_sum);
                                r_res_ch    <= r_mux;
                                r_res_ovr   <= w_ovr_any;
                                r_res_valid <= 1'b1;
                            end
                        end
                    end
                    S_OUTPUT: begin
                        if (r_res_valid && res_ready) begin
                            r_res_valid <= 1'b0;
                            if (!w_scan_done) r_mux <= w_nxt_ch;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mux_sel   = r_mux;
    assign dec_clear = (r_state == S_CLEAR);
    assign busy      = (r_state != S_IDLE);
    assign res_data  = r_res_data;
    assign res_ch    = r_res_ch;
    assign res_ovr   = r_res_ovr;
    assign res_valid = r_res_valid;
    assign err_mask  = r_err_mask;

endmodule

// File: tb/tb_sd_conv_sequencer.sv
// Randomized scoreboard bench for sd_conv_sequencer; a second instance covers the
// no-discard, one-cycle-settle build.
module tb_sd_conv_sequencer;

    localparam int          SETTLE = 16;
    localparam int          DISC   = 2;
    localparam int          AVGL   = 2;
    localparam int          AVGN   = 1 << AVGL;
    localparam logic [32:0] OVR    = 33'h1_FFFF_FF00;

    typedef struct {
        logic [32:0] data;
        logic [1:0]  ch;
        logic        ovr;
    } exp_t;

    logic        clk, reset;
    logic        start, continuous, abort, dec_valid, res_ready;
    logic [3:0]  ch_mask;
    logic [32:0] dec_data;
    logic [1:0]  mux_sel, res_ch;
    logic        dec_clear, busy, res_ovr, res_valid, err_mask;
    logic [32:0] res_data;

    logic        start0, dec_valid0, res_ready0, continuous0, abort0;
    logic [3:0]  ch_mask0;
    logic [32:0] dec_data0;
    logic [1:0]  mux_sel0, res_ch0;
    logic        dec_clear0, busy0, res_ovr0, res_valid0, err_mask0;
    logic [32:0] res_data0;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [32:0] words[4];
    bit          rdy_auto = 1'b1;

    sd_conv_sequencer #(.NCH(4), .CH_W(2), .DW(33), .SETTLE_CYC(SETTLE), .DISCARD(DISC),
                        .AVG_LOG2(AVGL), .OVR_THRESH(OVR)) u_dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .ch_mask(ch_mask),
        .abort(abort), .dec_valid(dec_valid), .dec_data(dec_data), .mux_sel(mux_sel),
        .dec_clear(dec_clear), .busy(busy), .res_data(res_data), .res_ch(res_ch),
        .res_ovr(res_ovr), .res_valid(res_valid), .res_ready(res_ready), .err_mask(err_mask)
    );

    sd_conv_sequencer #(.NCH(4), .CH_W(2), .DW(33), .SETTLE_CYC(1), .DISCARD(0),
                        .AVG_LOG2(AVGL), .OVR_THRESH(OVR)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .continuous(continuous0), .ch_mask(ch_mask0),
        .abort(abort0), .dec_valid(dec_valid0), .dec_data(dec_data0), .mux_sel(mux_sel0),
        .dec_clear(dec_clear0), .busy(busy0), .res_data(res_data0), .res_ch(res_ch0),
        .res_ovr(res_ovr0), .res_valid(res_valid0), .res_ready(res_ready0), .err_mask(err_mask0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] rand_word();
        logic [32:0] v;
        case ($urandom_range(0, 5))
            0:       v = OVR - 33'd1 + 33'($urandom_range(0, 2));
            1:       v = 33'($urandom_range(0, 15));
            default: v = {1'($urandom_range(0, 1)), $urandom()};
        endcase
        return v;
    endfunction

    // Ready generator: random acceptance unless a test takes manual control.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_auto) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every accepted result is compared with the oldest expectation.
    logic        hold_prev = 1'b0;
    logic [35:0] held;
    always @(negedge clk) begin
        if (reset) begin
            if (hold_prev && res_valid)
                chk("held result stable", {res_data, res_ch, res_ovr}, held);
            if (res_valid && res_ready && !abort) begin
                if (sb.size() == 0) begin
                    chk("unexpected result", 64'(res_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_ch",   64'(res_ch),   64'(e.ch));
                    chk("res_ovr",  64'(res_ovr),  64'(e.ovr));
                end
            end
            hold_prev = res_valid && !res_ready && !abort;
            held      = {res_data, res_ch, res_ovr};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic wait_clear(output bit ok);
        int n = 0;
        while (dec_clear !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        ok = (dec_clear === 1'b1);
        if (!ok) chk("dec_clear timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk("busy drops at scan end", 64'(busy), 64'd0);
    endtask

    task automatic strobe(input logic [32:0] v);
        repeat ($urandom_range(0, 2)) tick();
        dec_data  = v;
        dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
    endtask

    // One channel conversion as seen by the decimator: wait for the clear, feed words,
    // and record the average the sequencer must report.
    task automatic do_channel(input logic [1:0] ch, input bit fixed);
        bit          ok;
        logic [63:0] sum;
        logic        ovr;
        logic [32:0] v;
        exp_t        e;
        wait_clear(ok);
        if (!ok) return;
        chk("mux_sel at clear", 64'(mux_sel), 64'(ch));
        dec_data  = rand_word();
        dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        sum = '0;
        ovr = 1'b0;
        for (int i = 0; i < DISC + AVGN; i++) begin
            v = (fixed && i >= DISC) ? words[i - DISC] : rand_word();
            if (i >= DISC) begin
                sum += 64'(v);
                ovr |= (v >= OVR);
            end
            strobe(v);
        end
        e.data = 33'(sum / AVGN);
        e.ch   = ch;
        e.ovr  = ovr;
        sb.push_back(e);
    endtask

    task automatic go(input logic [3:0] m, input logic c);
        ch_mask    = m;
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        bit          ok;
        bit          seen;
        logic [32:0] k;
        logic [3:0]  m;
        logic [63:0] s0;

        reset = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = '0; abort = 1'b0;
        dec_valid = 1'b0; dec_data = '0;
        start0 = 1'b0; ch_mask0 = '0; dec_valid0 = 1'b0; dec_data0 = '0;
        res_ready0 = 1'b1; continuous0 = 1'b0; abort0 = 1'b0;
        repeat (3) tick();
        chk("reset mux_sel",   64'(mux_sel),   64'd0);
        chk("reset dec_clear", 64'(dec_clear), 64'd0);
        chk("reset busy",      64'(busy),      64'd0);
        chk("reset res_data",  64'(res_data),  64'd0);
        chk("reset res_ch",    64'(res_ch),    64'd0);
        chk("reset res_ovr",   64'(res_ovr),   64'd0);
        chk("reset res_valid", 64'(res_valid), 64'd0);
        chk("reset err_mask",  64'(err_mask),  64'd0);
        reset = 1'b1;
        tick();

        // single channel, known words
        go(4'b0100, 1'b0);
        chk("busy after start", 64'(busy), 64'd1);
        chk("mux_sel after start", 64'(mux_sel), 64'd2);
        cnt = 1;
        while (dec_clear !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("start to dec_clear cycles", 64'(cnt), 64'(SETTLE + 1));
        words = '{33'd100, 33'd104, 33'd108, 33'd112};
        do_channel(2'd2, 1'b1);
        wait_idle();

        // scan order with constant data; a start mid-scan must be ignored
        k = rand_word();
        words = '{k, k, k, k};
        go(4'b1011, 1'b0);
        do_channel(2'd0, 1'b1);
        ch_mask = 4'b1111; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        do_channel(2'd1, 1'b1);
        do_channel(2'd3, 1'b1);
        wait_idle();
        repeat (30) tick();
        chk("stays idle after single scan", 64'(busy), 64'd0);

        // backpressure with strobes arriving while the result waits
        rdy_auto = 1'b0;
        res_ready = 1'b0;
        go(4'b0011, 1'b0);
        do_channel(2'd0, 1'b0);
        repeat (20) begin
            dec_data = rand_word();
            dec_valid = $urandom_range(0, 1) != 0;
            tick();
        end
        dec_valid = 1'b0;
        chk("result held under backpressure", 64'(res_valid), 64'd1);
        rdy_auto = 1'b1;
        do_channel(2'd1, 1'b0);
        wait_idle();

        // overrange and truncation
        words = '{33'd0, 33'd1, 33'h1_FFFF_FFFF, 33'd2};
        go(4'b1000, 1'b0);
        do_channel(2'd3, 1'b1);
        wait_idle();

        // continuous single channel, then abort during FLUSH
        go(4'b0001, 1'b1);
        repeat (3) do_channel(2'd0, 1'b0);
        wait_clear(ok);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("busy after abort", 64'(busy), 64'd0);
        chk("res_valid after abort", 64'(res_valid), 64'd0);
        chk("mux_sel kept after abort", 64'(mux_sel), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            dec_data = rand_word();
            dec_valid = $urandom_range(0, 1) != 0;
            tick();
            if (res_valid || busy || dec_clear) seen = 1'b1;
        end
        dec_valid = 1'b0;
        chk("no activity after abort", 64'(seen), 64'd0);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        // abort beats a same-cycle res_ready on a pending result
        rdy_auto = 1'b0;
        res_ready = 1'b0;
        go(4'b0010, 1'b0);
        do_channel(2'd1, 1'b0);
        tick();
        chk("pending result valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        res_ready = 1'b0;
        chk("abort drops valid", 64'(res_valid), 64'd0);
        chk("abort clears busy", 64'(busy), 64'd0);
        sb.delete();
        rdy_auto = 1'b1;

        // empty mask
        go(4'b0000, 1'b1);
        chk("err_mask pulse", 64'(err_mask), 64'd1);
        chk("busy on empty mask", 64'(busy), 64'd0);
        tick();
        chk("err_mask one cycle", 64'(err_mask), 64'd0);

        // asynchronous reset while accumulating
        go(4'b0100, 1'b0);
        wait_clear(ok);
        tick();
        for (int i = 0; i < DISC + 1; i++) strobe(rand_word());
        chk("busy before mid reset", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid reset busy",    64'(busy),    64'd0);
        chk("mid reset mux_sel", 64'(mux_sel), 64'd0);
        chk("mid reset outputs", 64'({res_data, res_ch, res_ovr, res_valid, dec_clear, err_mask}), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // randomized scans
        for (int s = 0; s < 6; s++) begin
            m = 4'($urandom_range(1, 15));
            go(m, 1'b0);
            for (int c = 0; c < 4; c++)
                if (m[c]) do_channel(2'(c), 1'b0);
            wait_idle();
            chk("scoreboard drained", 64'(sb.size()), 64'd0);
        end

        // no-discard build: CLEAR leads straight into averaging
        ch_mask0 = 4'b0001;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cnt = 1;
        while (dec_clear0 !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("nodiscard start to clear", 64'(cnt), 64'd2);
        tick();
        words = '{33'd10, 33'd20, 33'd30, 33'd41};
        s0 = '0;
        for (int i = 0; i < AVGN; i++) begin
            dec_data0 = words[i];
            dec_valid0 = 1'b1;
            s0 += 64'(words[i]);
            tick();
        end
        dec_valid0 = 1'b0;
        cnt = 0;
        while (res_valid0 !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("nodiscard res_valid", 64'(res_valid0), 64'd1);
        chk("nodiscard res_data", 64'(res_data0), s0 / AVGN);
        chk("nodiscard res_ch", 64'(res_ch0), 64'd0);
        repeat (3) tick();
        chk("nodiscard busy drops", 64'(busy0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
